instr_encoder: RTL and testbench

Encodes operation requests (operation, register fields, shamt, immediate) into 32-bit MIPS instruction words and buffers them in a small FIFO for a consumer such as an instruction injection port or a test stimulus source feeding fetch. It covers exactly the instruction set the core's control decoder accepts: ADD, SUB, AND, OR, SLT, SLL, SRL, SRA, ADDI, LW, SW and BEQ. Words it emits must decode to the intended control signals. Unsupported operations are dropped and counted.

---
 rtl/instr_encoder_if.sv | 35 +++
 rtl/instr_encoder.sv | 97 +++++++++
 tb/tb_instr_encoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
//   Bundles the request side, the FIFO output side and the status outputs of
//   instr_encoder. The producer/consumer uses the master modport and the
//   encoder uses the slave modport.
//   Request : flush, in_valid/in_ready, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm
//   Output  : out_valid/out_ready, out_instr
//   Status  : level (occupancy), err_count (saturating invalid-op count)
interface instr_encoder_if #(parameter int DEPTH = 4);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [4:0]    in_shamt;
  logic [15:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [LW-1:0] level;
  logic [7:0]    err_count;

  modport master (
    output flush, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, level, err_count
  );

  modport slave (
    input  flush, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    output in_ready, out_valid, out_instr, level, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs operation requests into 32-bit MIPS words (ADD SUB AND OR SLT SLL
//   SRL SRA ADDI LW SW BEQ) and queues them in a DEPTH-entry FIFO. Invalid
//   opcodes (12-15) are accepted, dropped and counted in err_count.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : instr_encoder_if slave (request, FIFO output, level, err_count)
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4,  OP_SLL = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8,  OP_LW  = 4'd9,  OP_SW  = 4'd10, OP_BEQ = 4'd11;

  logic [31:0] word;
  logic        op_ok;

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic full, empty, accept, push, pop;

  // Encoder: R-type ignores imm; shifts force rs=0, other R-type force shamt=0;
  // I-type ignores rd/shamt.
  always_comb begin
    word  = '0;
    op_ok = 1'b1;
    case (bus.in_op)
      OP_ADD:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20};
      OP_SUB:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22};
      OP_AND:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24};
      OP_OR:   word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25};
      OP_SLT:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2A};
      OP_SLL:  word = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00};
      OP_SRL:  word = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h02};
      OP_SRA:  word = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h03};
      OP_ADDI: word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_LW:   word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_SW:   word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_BEQ:  word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
      default: op_ok = 1'b0;
    endcase
  end

  // Extra pointer MSB distinguishes full (MSBs differ, index equal) from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_instr = mem_q[rptr_q[AW-1:0]];
  assign bus.level     = wptr_q - rptr_q;
  assign bus.err_count = err_q;

  // A flush cycle discards the request entirely, including its error count.
  assign accept = bus.in_valid && !full && !bus.flush;
  assign push   = accept && op_ok;
  assign pop    = bus.out_ready && !empty && !bus.flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    err_d  = err_q;
    if (bus.flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end
    if (accept && !op_ok && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      err_q  <= err_d;
    end
  end

  // Storage needs no reset; contents are only visible while out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= word;
  end
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;
  logic [31:0] mdl [$];

  instr_encoder_if #(.DEPTH(DEPTH)) bus ();

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of ADDI-payload traffic, checked against the queue model.
  task automatic step(input bit dp, input logic [15:0] pl, input bit dpop);
    bit pushok, popok;
    bus.in_valid = dp;
    bus.in_op    = 4'd8;
    bus.in_rs    = 5'd0;
    bus.in_rt    = 5'd0;
    bus.in_imm   = pl;
    bus.out_ready = dpop;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, mdl.size() < DEPTH});
    chk("level", {29'd0, bus.level}, mdl.size());
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mdl.size() > 0});
    if (mdl.size() > 0) chk("head", bus.out_instr, mdl[0]);
    pushok = dp && (mdl.size() < DEPTH);
    popok  = dpop && (mdl.size() > 0);
    tick();
    if (popok)  void'(mdl.pop_front());
    if (pushok) mdl.push_back(32'h2000_0000 | {16'd0, pl});
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Push one request into an empty FIFO, check the word, then pop it.
  task automatic enc(input string tag, input logic [3:0] op, input logic [4:0] rs, rt, rd, sh,
                     input logic [15:0] imm, input logic [31:0] exp);
    bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = sh; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_lvl"}, {29'd0, bus.level}, 32'd1);
    chk(tag, bus.out_instr, exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bit any_valid;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_shamt = '0; bus.in_imm = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_level", {29'd0, bus.level}, 32'd0);
    chk("rst_err", {24'd0, bus.err_count}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Directed encodings (ADD uses shamt=5 and imm=FFFF to show they are ignored)
    enc("add",  4'd0, 5'd1, 5'd2, 5'd3, 5'd5,  16'hFFFF, 32'h0022_1820);
    enc("sub",  4'd1, 5'd4, 5'd5, 5'd6, 5'd0,  16'h0000, 32'h0085_3022);
    enc("and",  4'd2, 5'd1, 5'd2, 5'd3, 5'd0,  16'h0000, 32'h0022_1824);
    enc("or",   4'd3, 5'd1, 5'd2, 5'd3, 5'd0,  16'h0000, 32'h0022_1825);
    enc("slt",  4'd4, 5'd1, 5'd2, 5'd3, 5'd0,  16'h0000, 32'h0022_182A);
    enc("sll",  4'd5, 5'd7, 5'd5, 5'd4, 5'd2,  16'h0000, 32'h0005_2080);
    enc("srl",  4'd6, 5'd7, 5'd5, 5'd4, 5'd2,  16'h0000, 32'h0005_2082);
    enc("sra",  4'd7, 5'd9, 5'd2, 5'd1, 5'd31, 16'h0000, 32'h0002_0FC3);
    enc("addi", 4'd8, 5'd1, 5'd2, 5'd9, 5'd3,  16'h1234, 32'h2022_1234);
    enc("sw",   4'd10, 5'd2, 5'd3, 5'd0, 5'd0, 16'h8000, 32'hAC43_8000);

    // LW then BEQ, in order
    bus.in_op = 4'd9; bus.in_rs = 5'd29; bus.in_rt = 5'd8; bus.in_rd = 5'd31;
    bus.in_shamt = 5'd0; bus.in_imm = 16'h0004; bus.in_valid = 1'b1;
    tick();
    bus.in_op = 4'd11; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_imm = 16'hFFFF;
    tick();
    bus.in_valid = 1'b0;
    chk("lwbeq_lvl", {29'd0, bus.level}, 32'd2);
    chk("lw", bus.out_instr, 32'h8FA8_0004);
    bus.out_ready = 1'b1;
    tick();
    chk("beq", bus.out_instr, 32'h1022_FFFF);
    tick();
    bus.out_ready = 1'b0;
    chk("lwbeq_empty", {31'd0, bus.out_valid}, 32'd0);

    // Fill past full, then concurrent push/pop across pointer wrap, then drain
    for (int k = 0; k < 5; k++) step(1'b1, 16'(k), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'(5 + i), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b1);
    chk("drain_lvl", {29'd0, bus.level}, 32'd0);

    // 300 invalid ops: nothing enqueued, err_count saturates
    any_valid = 1'b0;
    bus.in_op = 4'd13; bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      any_valid |= bus.out_valid;
      if (i == 9)   chk("err_10", {24'd0, bus.err_count}, 32'd10);
      if (i == 254) chk("err_255", {24'd0, bus.err_count}, 32'hFF);
    end
    bus.in_valid = 1'b0;
    chk("err_sat", {24'd0, bus.err_count}, 32'hFF);
    chk("inv_no_valid", {31'd0, any_valid}, 32'd0);

    // Flush with 3 words held and a simultaneous push
    for (int k = 0; k < 3; k++) step(1'b1, 16'h100 + 16'(k), 1'b0);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_op = 4'd8; bus.in_imm = 16'h01FF;
    bus.out_ready = 1'b1;
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    mdl.delete();
    chk("flush_lvl", {29'd0, bus.level}, 32'd0);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_err_kept", {24'd0, bus.err_count}, 32'hFF);
    step(1'b1, 16'h0055, 1'b0);
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b0);

    // Asynchronous reset mid-stream with 3 words held
    for (int k = 0; k < 3; k++) step(1'b1, 16'h200 + 16'(k), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lvl", {29'd0, bus.level}, 32'd0);
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst_err", {24'd0, bus.err_count}, 32'd0);
    mdl.delete();
    @(negedge clk) rst_n = 1'b1;
    tick();
    step(1'b1, 16'h0077, 1'b0);
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
